// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back request record.
package rf_pkg;
  localparam int RF_ADDR_W = 6;
  localparam int RF_DATA_W = 16;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic                 vld;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arb_if.sv
// Write-back requester bus, RF write port and decode hazard lookup.
interface rf_wb_arb_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
);
  // Handshake: a transfer happens in any cycle where req_vld[i] & req_rdy[i];
  // requester i keeps vld/addr/data stable until then and may drop vld early.
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_dst_addr;
  logic [DATA_W-1:0]         rf_dst;
  logic [ADDR_W-1:0]         hz_addr0;
  logic [ADDR_W-1:0]         hz_addr1;
  logic                      hz_pend0;
  logic                      hz_pend1;

  modport master (
    output req_vld, req_addr, req_data, hz_addr0, hz_addr1,
    input  req_rdy, rf_we, rf_dst_addr, rf_dst, hz_pend0, hz_pend1
  );

  modport slave (
    input  req_vld, req_addr, req_data, hz_addr0, hz_addr1,
    output req_rdy, rf_we, rf_dst_addr, rf_dst, hz_pend0, hz_pend1
  );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin grant: first set request at or after ptr wins.
module rr_arb #(
  parameter  int NUM_REQ = 3,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_vld
);
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Scan farthest-first so the candidate closest to ptr overwrites the rest.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arb.sv
// Write-back arbiter: round-robin grant onto the registered RF write port,
// plus pending-write hazard lookup for the two decode read addresses.
module rf_wb_arb
  import rf_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int ADDR_W  = RF_ADDR_W,
  parameter  int DATA_W  = RF_DATA_W,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rf_wb_arb_if.slave       bus,
  output logic [PTR_W-1:0] rr_ptr_dbg
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_vld;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               hit0;
  logic               hit1;

  assign req_eff = flush ? '0 : bus.req_vld;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req     (req_eff),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.req_rdy = gnt;
  assign win_addr    = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign win_data    = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // Grants to the zero register are consumed but never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      we_q   <= 1'b0;
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      we_q   <= (win_addr != ZERO_ADDR);
      addr_q <= win_addr;
      data_q <= win_data;
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.rf_we       = we_q;
  assign bus.rf_dst_addr = addr_q;
  assign bus.rf_dst      = data_q;
  assign rr_ptr_dbg      = rr_ptr;

  // Hazard looks at raw req_vld so a flushed cycle still reports queued writes.
  always_comb begin
    hit0 = we_q && (addr_q == bus.hz_addr0);
    hit1 = we_q && (addr_q == bus.hz_addr1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_vld[i] && (bus.req_addr[i*ADDR_W +: ADDR_W] == bus.hz_addr0)) hit0 = 1'b1;
      if (bus.req_vld[i] && (bus.req_addr[i*ADDR_W +: ADDR_W] == bus.hz_addr1)) hit1 = 1'b1;
    end
  end

  assign bus.hz_pend0 = hit0 && (bus.hz_addr0 != ZERO_ADDR);
  assign bus.hz_pend1 = hit1 && (bus.hz_addr1 != ZERO_ADDR);
endmodule
